decim_frame_ctrl: RTL and testbench
===================================

DECIM_FRAME_CTRL -- requirements
Module: decim_frame_ctrl

Interface
REQ-001 Parameter FRAME_LEN, 1024, decimated I/Q samples per frame (power of two, 8..4096).
REQ-002 Parameter SETTLE, 48, decimated samples discarded after a tune change (1..255).
REQ-003 Parameter DECIM, 3, adc_clk cycles per decimated sample (2..4).
REQ-004 adc_clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to retune and capture one frame.
REQ-007 abort  in  1  cancels any activity and returns the block to IDLE.
REQ-008 tune_req  in  20  NCO phase increment to apply for the requested frame.
REQ-009 sin_in, cos_in  in  24 each  FIR outputs from the decimator datapath, valid every adc_clk.
REQ-010 ack  in  1  consumer has read the frame and releases the buffer.
REQ-011 sg_tune  out  20  phase increment driven to the NCO.
REQ-012 wr_en  out  1  buffer write strobe.
REQ-013 wr_addr  out  log2(FRAME_LEN)  buffer write address.
REQ-014 wr_sin, wr_cos  out  24 each  registered sample data for the buffer.
REQ-015 busy  out  1  high in SETTLE or CAPTURE.
REQ-016 done  out  1  one-cycle pulse on the final frame write.
REQ-017 frame_valid  out  1  high in HOLD (frame complete, awaiting ack).

Function
REQ-018 The block SHALL run a free-running phase counter that loads DECIM-1, decrements each cycle, and reloads DECIM-1 after 0; strobe = (counter==0).
REQ-019 The FSM SHALL have the states IDLE, SETTLE, CAPTURE and HOLD.
REQ-020 IDLE: on start, the block SHALL register tune_req into sg_tune, clear the settle and sample counters, and enter SETTLE.
REQ-021 SETTLE: each strobe SHALL increment the settle count; on the strobe that completes SETTLE samples, the block SHALL enter CAPTURE; no writes occur.
REQ-022 CAPTURE: on each strobe, the block SHALL register wr_en=1, wr_addr=sample count, wr_sin=sin_in and wr_cos=cos_in (latency 1 cycle from the strobe), then increment the sample count.
REQ-023 wr_en SHALL be high for exactly one cycle per strobe and low in every other state.
REQ-024 On the strobe writing address FRAME_LEN-1, the block SHALL assert done coincident with that wr_en and enter HOLD; the address never wraps within a frame.
REQ-025 HOLD: frame_valid=1; on ack the block SHALL enter IDLE the next cycle.
REQ-026 start outside IDLE SHALL be ignored, and sg_tune SHALL remain unchanged.
REQ-027 start and ack in the same HOLD cycle: ack SHALL be taken and start ignored.
REQ-028 ack outside HOLD SHALL be ignored.
REQ-029 abort SHALL have priority over start/ack/strobe: next state is IDLE, wr_en=0 and done=0 that cycle, and sg_tune is retained.
REQ-030 busy and frame_valid SHALL be decoded from registered state (glitch-free, mutually exclusive).

Reset
REQ-031 reset SHALL set: state=IDLE, phase counter=DECIM-1, sg_tune=0, wr_en=0, wr_addr=0, wr_sin=wr_cos=0, done=0, busy=0, frame_valid=0, and both counters=0.
REQ-032 reset mid-frame SHALL discard the partial frame, with no done pulse.
REQ-033 reset SHALL take priority over abort and start.

Structure
REQ-034 A shared package SHALL hold the state enumeration, the sample width (24), the tune width (20), and the default FRAME_LEN/SETTLE/DECIM constants.
REQ-035 A single sub-module, decim_strobe_gen (the phase counter plus strobe), SHALL be natural; all other logic SHALL be flat.

Verification (bench FRAME_LEN=8, SETTLE=2, DECIM=3)
REQ-036 Reset, then start with tune_req=0x12345 -> sg_tune=0x12345 next cycle; 2 strobes with no wr_en; then 8 wr_en pulses spaced 3 cycles at addresses 0..7 carrying sin_in/cos_in from each strobe; done with address 7; frame_valid=1.
REQ-037 In HOLD, hold ack low for 20 cycles -> no writes and frame_valid held; pulse ack -> IDLE, frame_valid=0 next cycle.
REQ-038 start with tune 0x00001 during CAPTURE at address 3 -> sg_tune unchanged and capture completes 0..7 normally.
REQ-039 abort at address 5 -> wr_en=0 that cycle, no done, busy=0 next cycle; a subsequent start restarts at SETTLE and writes from address 0.
REQ-040 reset asserted in SETTLE, and separately in HOLD together with start and ack -> all outputs match their reset values the next cycle.
REQ-041 start and ack in the same HOLD cycle -> IDLE with no new capture; a start 1 cycle later -> new frame begins.

Source files
------------

// File: rtl/decim_frame_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// decim_frame_ctrl_pkg
//   Shared types and constants for the decimated I/Q frame capture controller.
//   Holds the controller state enumeration, datapath widths and the default
//   frame/settle/decimation parameters used by decim_frame_ctrl and
//   decim_strobe_gen.
// ---------------------------------------------------------------------------
package decim_frame_ctrl_pkg;

  // Datapath widths
  localparam int SAMPLE_W = 24;   // FIR output sample width (sin/cos)
  localparam int TUNE_W   = 20;   // NCO phase increment width

  // Default build parameters
  localparam int DEF_FRAME_LEN = 1024;  // decimated samples per frame (power of two)
  localparam int DEF_SETTLE    = 48;    // decimated samples discarded after retune
  localparam int DEF_DECIM     = 3;     // adc_clk cycles per decimated sample

  // Counter width for the settle count (SETTLE is limited to 1..255)
  localparam int SETTLE_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

endpackage : decim_frame_ctrl_pkg

// File: rtl/decim_frame_ctrl_strobe_gen.sv
// ---------------------------------------------------------------------------
// decim_strobe_gen
//   Free-running decimation phase counter. The counter loads DECIM-1,
//   counts down once per adc_clk and reloads DECIM-1 after reaching zero.
//   strobe is high for the one cycle in every DECIM where the counter is 0,
//   marking the cycle in which sin_in/cos_in carry a fresh decimated sample.
//
//   Ports
//     adc_clk  in   sole clock
//     reset    in   synchronous active-high reset (counter -> DECIM-1)
//     strobe   out  one-cycle decimated-sample marker
// ---------------------------------------------------------------------------
module decim_strobe_gen
  import decim_frame_ctrl_pkg::*;
#(
  parameter int DECIM = DEF_DECIM
) (
  input  logic adc_clk,
  input  logic reset,
  output logic strobe
);

  localparam int PH_W = (DECIM > 2) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0] PH_RELOAD = PH_W'(DECIM - 1);

  logic [PH_W-1:0] phase_q;
  logic [PH_W-1:0] phase_d;

  always_comb begin
    phase_d = phase_q - 1'b1;
    if (phase_q == '0) begin
      phase_d = PH_RELOAD;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (reset) begin
      phase_q <= PH_RELOAD;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign strobe = (phase_q == '0);

endmodule : decim_strobe_gen

// File: rtl/decim_frame_ctrl.sv
// ---------------------------------------------------------------------------
// decim_frame_ctrl
//   Retune-and-capture controller for the decimated I/Q path. A start in
//   IDLE latches a new NCO increment, discards SETTLE decimated samples while
//   the filters flush, then writes FRAME_LEN samples into the frame buffer
//   (one write per decimation strobe) and holds the frame until the consumer
//   acknowledges it.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | waiting for start; sg_tune holds the last applied increment
//   SETTLE   | counting SETTLE strobes after retune, no buffer writes
//   CAPTURE  | one buffer write per strobe, addresses 0..FRAME_LEN-1
//   HOLD     | frame complete, frame_valid high until ack
//
//   Ports
//     adc_clk      in   sole clock
//     reset        in   synchronous active-high reset
//     start        in   retune + capture request (honoured only in IDLE)
//     abort        in   cancel any activity, return to IDLE
//     tune_req     in   NCO increment for the requested frame
//     sin_in       in   FIR sine output, valid every cycle
//     cos_in       in   FIR cosine output, valid every cycle
//     ack          in   consumer releases the frame buffer (HOLD only)
//     sg_tune      out  NCO phase increment
//     wr_en        out  buffer write strobe
//     wr_addr      out  buffer write address
//     wr_sin       out  registered sine sample for the buffer
//     wr_cos       out  registered cosine sample for the buffer
//     busy         out  high in SETTLE or CAPTURE
//     done         out  one-cycle pulse with the final frame write
//     frame_valid  out  high in HOLD
// ---------------------------------------------------------------------------
module decim_frame_ctrl
  import decim_frame_ctrl_pkg::*;
#(
  parameter  int FRAME_LEN = DEF_FRAME_LEN,
  parameter  int SETTLE    = DEF_SETTLE,
  parameter  int DECIM     = DEF_DECIM,
  localparam int ADDR_W    = $clog2(FRAME_LEN)
) (
  input  logic                adc_clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [TUNE_W-1:0]   tune_req,
  input  logic [SAMPLE_W-1:0] sin_in,
  input  logic [SAMPLE_W-1:0] cos_in,
  input  logic                ack,
  output logic [TUNE_W-1:0]   sg_tune,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [SAMPLE_W-1:0] wr_sin,
  output logic [SAMPLE_W-1:0] wr_cos,
  output logic                busy,
  output logic                done,
  output logic                frame_valid
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE - 1);
  localparam logic [ADDR_W-1:0]       ADDR_LAST   = ADDR_W'(FRAME_LEN - 1);

  logic strobe;

  decim_strobe_gen #(
    .DECIM (DECIM)
  ) u_strobe_gen (
    .adc_clk (adc_clk),
    .reset   (reset),
    .strobe  (strobe)
  );

  state_e                  state_q,      state_d;
  logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [ADDR_W-1:0]       sample_cnt_q, sample_cnt_d;
  logic [TUNE_W-1:0]       sg_tune_q,    sg_tune_d;
  logic                    wr_en_q,      wr_en_d;
  logic [ADDR_W-1:0]       wr_addr_q,    wr_addr_d;
  logic [SAMPLE_W-1:0]     wr_sin_q,     wr_sin_d;
  logic [SAMPLE_W-1:0]     wr_cos_q,     wr_cos_d;
  logic                    done_q,       done_d;

  // Next-state and next-output logic. Write data, address and tune hold
  // their last values unless explicitly updated; wr_en and done are pulses.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    sample_cnt_d = sample_cnt_q;
    sg_tune_d    = sg_tune_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_sin_d     = wr_sin_q;
    wr_cos_d     = wr_cos_q;
    done_d       = 1'b0;

    if (abort) begin
      // Abort wins over start/ack/strobe; the tune word is kept so the NCO
      // does not jump on a cancelled capture.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sg_tune_d    = tune_req;
            settle_cnt_d = '0;
            sample_cnt_d = '0;
            state_d      = ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (strobe) begin
            settle_cnt_d = settle_cnt_q + 1'b1;
            if (settle_cnt_q == SETTLE_LAST) begin
              state_d = ST_CAPTURE;
            end
          end
        end

        ST_CAPTURE: begin
          if (strobe) begin
            wr_en_d   = 1'b1;
            wr_addr_d = sample_cnt_q;
            wr_sin_d  = sin_in;
            wr_cos_d  = cos_in;
            if (sample_cnt_q == ADDR_LAST) begin
              // Leave the sample count parked on the last address so it
              // never wraps inside a frame.
              done_d  = 1'b1;
              state_d = ST_HOLD;
            end else begin
              sample_cnt_d = sample_cnt_q + 1'b1;
            end
          end
        end

        ST_HOLD: begin
          // ack takes precedence; a coincident start is simply not looked at.
          if (ack) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge adc_clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      sample_cnt_q <= '0;
      sg_tune_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_sin_q     <= '0;
      wr_cos_q     <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      sg_tune_q    <= sg_tune_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_sin_q     <= wr_sin_d;
      wr_cos_q     <= wr_cos_d;
      done_q       <= done_d;
    end
  end

  assign sg_tune     = sg_tune_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_sin      = wr_sin_q;
  assign wr_cos      = wr_cos_q;
  assign done        = done_q;

  // Pure decodes of the state register: no combinational input paths.
  assign busy        = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
  assign frame_valid = (state_q == ST_HOLD);

endmodule : decim_frame_ctrl

// File: tb/tb_decim_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_decim_frame_ctrl
//   Self-checking bench for decim_frame_ctrl (FRAME_LEN=8, SETTLE=2, DECIM=3).
//   A behavioural model counts decimated strobes from the cycle number since
//   reset and counts strobes since the accepted start; the k-th strobe of a
//   frame writes address k-SETTLE once k reaches SETTLE.
// ---------------------------------------------------------------------------
module tb_decim_frame_ctrl;

  localparam int FL = 8;
  localparam int ST = 2;
  localparam int DC = 3;

  localparam int M_IDLE   = 0;
  localparam int M_ACTIVE = 1;
  localparam int M_HOLD   = 2;

  logic        adc_clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [19:0] tune_req;
  logic [23:0] sin_in;
  logic [23:0] cos_in;
  logic        ack;
  logic [19:0] sg_tune;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [23:0] wr_sin;
  logic [23:0] wr_cos;
  logic        busy;
  logic        done;
  logic        frame_valid;

  decim_frame_ctrl #(
    .FRAME_LEN (FL),
    .SETTLE    (ST),
    .DECIM     (DC)
  ) dut (
    .adc_clk     (adc_clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .tune_req    (tune_req),
    .sin_in      (sin_in),
    .cos_in      (cos_in),
    .ack         (ack),
    .sg_tune     (sg_tune),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_sin      (wr_sin),
    .wr_cos      (wr_cos),
    .busy        (busy),
    .done        (done),
    .frame_valid (frame_valid)
  );

  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ------------------------- behavioural model -----------------------------
  int          m_n;      // cycles since reset released
  int          m_mode;
  int          m_k;      // strobes seen since the accepted start
  bit          m_ok = 1'b0;
  logic [19:0] e_tune;
  logic        e_wr_en, e_done, e_busy, e_fv;
  logic [2:0]  e_addr;
  logic [23:0] e_sin, e_cos;

  always @(posedge adc_clk) begin
    if (reset) begin
      m_n = 0; m_mode = M_IDLE; m_k = 0;
      e_tune = '0; e_wr_en = 1'b0; e_done = 1'b0;
      e_addr = '0; e_sin = '0; e_cos = '0;
      m_ok = 1'b1;
    end else begin
      bit stb;
      stb = ((m_n % DC) == DC - 1);
      m_n++;
      e_wr_en = 1'b0;
      e_done  = 1'b0;
      if (abort) begin
        m_mode = M_IDLE;
      end else if (m_mode == M_IDLE) begin
        if (start) begin
          e_tune = tune_req;
          m_k    = 0;
          m_mode = M_ACTIVE;
        end
      end else if (m_mode == M_ACTIVE) begin
        if (stb) begin
          if (m_k >= ST) begin
            e_wr_en = 1'b1;
            e_addr  = 3'(m_k - ST);
            e_sin   = sin_in;
            e_cos   = cos_in;
            if (m_k - ST == FL - 1) begin
              e_done = 1'b1;
              m_mode = M_HOLD;
            end
          end
          m_k++;
        end
      end else begin
        if (ack) m_mode = M_IDLE;
      end
    end
    e_busy = (m_mode == M_ACTIVE);
    e_fv   = (m_mode == M_HOLD);
  end

  // ------------------------- compare + write log ---------------------------
  int cyc_cnt = 0;
  int wr_cnt, first_addr, done_addr, last_wr_cyc, gap_min, gap_max;

  task automatic clear_log();
    wr_cnt = 0; first_addr = -1; done_addr = -1;
    gap_min = 1000; gap_max = 0; last_wr_cyc = 0;
  endtask

  always @(negedge adc_clk) begin
    cyc_cnt++;
    if (m_ok) begin
      chk("sg_tune",     32'(sg_tune),     32'(e_tune));
      chk("wr_en",       32'(wr_en),       32'(e_wr_en));
      chk("wr_addr",     32'(wr_addr),     32'(e_addr));
      chk("wr_sin",      32'(wr_sin),      32'(e_sin));
      chk("wr_cos",      32'(wr_cos),      32'(e_cos));
      chk("done",        32'(done),        32'(e_done));
      chk("busy",        32'(busy),        32'(e_busy));
      chk("frame_valid", 32'(frame_valid), 32'(e_fv));
      if (wr_en === 1'b1) begin
        if (wr_cnt == 0) begin
          first_addr = int'(wr_addr);
        end else begin
          if (cyc_cnt - last_wr_cyc < gap_min) gap_min = cyc_cnt - last_wr_cyc;
          if (cyc_cnt - last_wr_cyc > gap_max) gap_max = cyc_cnt - last_wr_cyc;
        end
        last_wr_cyc = cyc_cnt;
        wr_cnt++;
      end
      if (done === 1'b1) done_addr = int'(wr_addr);
    end
  end

  always @(negedge adc_clk) begin
    sin_in = 24'($urandom);
    cos_in = 24'($urandom);
  end

  // ------------------------- directed helpers ------------------------------
  task automatic step();
    @(negedge adc_clk);
    #1;
  endtask

  task automatic pulse_start(input logic [19:0] t);
    tune_req = t;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic wait_fv(input string nm);
    for (int i = 0; i < 200 && frame_valid !== 1'b1; i++) step();
    chk(nm, 32'(frame_valid), 32'd1);
  endtask

  task automatic wait_wr(input string nm, input logic [2:0] a);
    for (int i = 0; i < 200 && !(wr_en === 1'b1 && wr_addr == a); i++) step();
    chk(nm, 32'(wr_en === 1'b1 && wr_addr == a), 32'd1);
  endtask

  task automatic chk_rst(input string nm);
    chk({nm, "_sg_tune"}, 32'(sg_tune), 32'd0);
    chk({nm, "_wr_en"},   32'(wr_en),   32'd0);
    chk({nm, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({nm, "_wr_sin"},  32'(wr_sin),  32'd0);
    chk({nm, "_wr_cos"},  32'(wr_cos),  32'd0);
    chk({nm, "_done"},    32'(done),    32'd0);
    chk({nm, "_busy"},    32'(busy),    32'd0);
    chk({nm, "_fv"},      32'(frame_valid), 32'd0);
  endtask

  // ------------------------- stimulus --------------------------------------
  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b0; tune_req = '0;
    clear_log();
    repeat (3) step();
    chk_rst("por");
    reset = 1'b0;
    step();

    // Basic frame with tune 0x12345
    clear_log();
    pulse_start(20'h12345);
    chk("tune_load", 32'(sg_tune), 32'h12345);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_fv("s1_frame_valid");
    chk("s1_wr_count", 32'(wr_cnt), 32'd8);
    chk("s1_first_addr", 32'(first_addr), 32'd0);
    chk("s1_done_addr", 32'(done_addr), 32'd7);
    chk("s1_gap_min", 32'(gap_min), 32'd3);
    chk("s1_gap_max", 32'(gap_max), 32'd3);

    // Hold without ack
    clear_log();
    repeat (20) step();
    chk("hold_no_writes", 32'(wr_cnt), 32'd0);
    chk("hold_fv", 32'(frame_valid), 32'd1);
    pulse_ack();
    chk("ack_fv_low", 32'(frame_valid), 32'd0);
    chk("ack_busy_low", 32'(busy), 32'd0);

    // start during CAPTURE is ignored
    clear_log();
    pulse_start(20'hABCDE);
    wait_wr("s3_reach_addr3", 3'd3);
    tune_req = 20'h00001;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("s3_tune_kept", 32'(sg_tune), 32'hABCDE);
    wait_fv("s3_frame_valid");
    chk("s3_wr_count", 32'(wr_cnt), 32'd8);
    chk("s3_done_addr", 32'(done_addr), 32'd7);
    pulse_ack();

    // abort on the strobe that would write address 5
    clear_log();
    pulse_start(20'h0F0F0);
    wait_wr("s4_reach_addr4", 3'd4);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wr_count", 32'(wr_cnt), 32'd5);
    chk("abort_tune_kept", 32'(sg_tune), 32'h0F0F0);
    clear_log();
    pulse_start(20'h31415);
    chk("restart_busy", 32'(busy), 32'd1);
    wait_fv("s4_frame_valid");
    chk("restart_first_addr", 32'(first_addr), 32'd0);
    chk("restart_wr_count", 32'(wr_cnt), 32'd8);
    pulse_ack();

    // reset in SETTLE with start+abort, then reset in HOLD with start+ack
    pulse_start(20'h22222);
    step();
    reset = 1'b1; start = 1'b1; abort = 1'b1;
    step();
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    chk_rst("rst_settle");
    pulse_start(20'h33333);
    wait_fv("s5_frame_valid");
    reset = 1'b1; start = 1'b1; ack = 1'b1;
    step();
    reset = 1'b0; start = 1'b0; ack = 1'b0;
    chk_rst("rst_hold");

    // start+ack together in HOLD, then start one cycle later
    pulse_start(20'h44444);
    wait_fv("s6_frame_valid");
    tune_req = 20'h55555; start = 1'b1; ack = 1'b1;
    step();
    start = 1'b0; ack = 1'b0;
    chk("s6_fv_low", 32'(frame_valid), 32'd0);
    chk("s6_busy_low", 32'(busy), 32'd0);
    chk("s6_tune_kept", 32'(sg_tune), 32'h44444);
    pulse_start(20'h77777);
    chk("s6_restart_busy", 32'(busy), 32'd1);
    chk("s6_restart_tune", 32'(sg_tune), 32'h77777);
    wait_fv("s6_frame_valid2");
    pulse_ack();

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      start    = ($urandom_range(0, 9) == 0);
      ack      = ($urandom_range(0, 4) == 0);
      abort    = ($urandom_range(0, 59) == 0);
      reset    = ($urandom_range(0, 499) == 0);
      tune_req = 20'($urandom);
      step();
    end
    start = 1'b0; ack = 1'b0; abort = 1'b0; reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_decim_frame_ctrl
